if_stage: RTL

Instruction fetch stage of the five-stage RISC-V core, directly upstream of the decode stage. Owns the fetch PC, issues in-order requests to instruction memory over a valid/ready channel, and buffers returned instructions with their PCs in a small FIFO. Presents one {pc, inst} pair per cycle to decode. Applies branch/jump redirects from decode, discarding every in-flight and buffered wrong-path fetch.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_stage_fetch_fifo.sv | 56 +++++
 rtl/if_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Core-wide constants shared by the fetch, decode and execute stages, plus the
// fetch credit check used to throttle instruction-memory requests.
package if_stage_pkg;

   localparam int CORE_PC_W   = 32;
   localparam int CORE_INST_W = 32;
   localparam logic [CORE_PC_W-1:0] CORE_RESET_PC = 32'h0000_0000;

   // A new fetch may issue only while in-flight plus buffered entries leave room.
   function automatic logic credit_free(input int unsigned outstanding,
                                        input int unsigned depth);
      return outstanding < depth;
   endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetched {pc, inst} pairs; flush overrides any
// same-cycle push or pop. Head data reads as zero while empty.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic                    i_flush,
   input  logic [WIDTH-1:0]        i_data,
   output logic                    o_valid,
   output logic [WIDTH-1:0]        o_data,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push & ~i_flush & (r_count != CW'(DEPTH));
   assign w_pop  = i_pop  & ~i_flush & (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and
// buffers returned {pc, inst} pairs for decode, squashing wrong-path fetches on redirect.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                  PC_WIDTH   = CORE_PC_W,
   parameter int                  INST_WIDTH = CORE_INST_W,
   parameter int                  DEPTH      = 2,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(CORE_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [PC_WIDTH-1:0]   imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   input  logic                  id_ready,
   output logic                  if_valid,
   output logic [PC_WIDTH-1:0]   if_pc,
   output logic [INST_WIDTH-1:0] if_inst
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = PC_WIDTH + INST_WIDTH;

   logic [PC_WIDTH-1:0] r_fetch_pc;
   logic [CW-1:0]       r_live;
   logic [CW-1:0]       r_stale;
   logic [PC_WIDTH-1:0] r_pcq [DEPTH];
   logic [AW-1:0]       r_pcq_wr;
   logic [AW-1:0]       r_pcq_rd;

   logic                w_req_fire;
   logic                w_resp_stale;
   logic                w_resp_live;
   logic                w_push;
   logic [CW-1:0]       w_fifo_count;
   logic [CW-1:0]       w_live_nxt;
   logic [CW-1:0]       w_stale_nxt;
   logic [PC_WIDTH-1:0] w_fetch_pc_nxt;
   logic [EW-1:0]       w_head;
   logic                w_unused_addr_lsbs;

   assign w_unused_addr_lsbs = ^redirect_pc[1:0];

   assign imem_req_valid = credit_free(32'(r_live) + 32'(r_stale) + 32'(w_fifo_count), DEPTH);
   assign imem_req_addr  = r_fetch_pc;

   assign w_req_fire   = imem_req_valid & imem_req_ready;
   assign w_resp_stale = imem_resp_valid & (r_stale != '0);
   assign w_resp_live  = imem_resp_valid & (r_stale == '0) & (r_live != '0);
   assign w_push       = w_resp_live & ~redirect_valid;

   // On redirect everything accepted so far and not answered this cycle turns stale.
   always_comb begin
      w_fetch_pc_nxt = r_fetch_pc;
      w_live_nxt     = r_live;
      w_stale_nxt    = r_stale;
      if (w_req_fire) w_fetch_pc_nxt = r_fetch_pc + PC_WIDTH'(4);
      if (redirect_valid) begin
         w_fetch_pc_nxt = {redirect_pc[PC_WIDTH-1:2], 2'b00};
         w_live_nxt     = '0;
         w_stale_nxt    = r_stale + r_live + CW'(w_req_fire)
                          - CW'(w_resp_stale) - CW'(w_resp_live);
      end else begin
         w_live_nxt  = r_live + CW'(w_req_fire) - CW'(w_resp_live);
         w_stale_nxt = r_stale - CW'(w_resp_stale);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_live     <= '0;
         r_stale    <= '0;
         r_pcq_wr   <= '0;
         r_pcq_rd   <= '0;
      end else begin
         r_fetch_pc <= w_fetch_pc_nxt;
         r_live     <= w_live_nxt;
         r_stale    <= w_stale_nxt;
         if (redirect_valid) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
         end else begin
            if (w_req_fire)  r_pcq_wr <= r_pcq_wr + AW'(1);
            if (w_resp_live) r_pcq_rd <= r_pcq_rd + AW'(1);
         end
      end
   end

   // PC queue holds only right-path requests, so its head pairs with the next live response.
   always_ff @(posedge clk) begin
      if (w_req_fire) r_pcq[r_pcq_wr] <= r_fetch_pc;
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fetch_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (id_ready),
      .i_flush (redirect_valid),
      .i_data  ({r_pcq[r_pcq_rd], imem_resp_data}),
      .o_valid (if_valid),
      .o_data  (w_head),
      .o_count (w_fifo_count)
   );

   assign if_pc   = w_head[EW-1:INST_WIDTH];
   assign if_inst = w_head[INST_WIDTH-1:0];

endmodule
